alu_flag_controller: RTL and testbench

- Execute-stage control block for the 16-bit ALU.
- Decodes the execute-stage ALU operation class into the ALU's 2-bit mode and carry-select controls.
- Owns the architectural condition-code register (CCR = {C,N,Z}) and applies per-op flag write masks.
- Clears flags after taken conditional jumps, and saves/restores the CCR on interrupt entry / RTI through a small shadow stack sequenced by an FSM.

---
 rtl/alu_flag_controller.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_flag_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_controller.sv
// ---------------------------------------------------------------------------
// alu_flag_controller
//
// Execute-stage control block for the 16-bit ALU. It decodes the ALU
// operation class into the ALU mode / carry-select controls, owns the
// architectural condition-code register (CCR = {C,N,Z}), applies per-op
// flag write masks, clears flags on taken conditional jumps, and saves /
// restores the CCR across interrupts through a small shadow stack.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous active-high reset
//   stall        in   1  freezes CCR, FSM, hold counter and shadow stack
//   flush        in   1  current execute op is treated as NOP
//   aluOp        in   3  000 NOP, 001 ADD, 010 NOT, 011 SETC, 100 CLRC,
//                        101 MOV, 110/111 NOP
//   aluFlags     in   3  {C,N,Z} produced by the ALU this cycle
//   jumpTaken    in   1  jump resolved taken this cycle
//   jumpType     in   2  00 JZ, 01 JN, 10 JC, 11 JMP
//   intReq       in   1  level interrupt request, held until intAck
//   rtiReq       in   1  single-cycle return-from-interrupt pulse
//   AlUmode      out  2  00 add, 01 not, 10 pass, 11 nop
//   carrySelect  out  2  00 reset, 01 set, 10 ALU-generated
//   ccr          out  3  registered {C,N,Z}
//   intAck       out  1  pulse on the cycle the CCR is saved
//   busy         out  1  high while saving / holding off flag writes
//   stackErr     out  1  pulse (one cycle after the RTI) on RTI with an
//                        empty shadow stack
// ---------------------------------------------------------------------------
module alu_flag_controller #(
  parameter int SHADOW_DEPTH    = 2,
  parameter int INT_HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  logic [2:0] aluOp,
  input  logic [2:0] aluFlags,
  input  logic       jumpTaken,
  input  logic [1:0] jumpType,
  input  logic       intReq,
  input  logic       rtiReq,
  output logic [1:0] AlUmode,
  output logic [1:0] carrySelect,
  output logic [2:0] ccr,
  output logic       intAck,
  output logic       busy,
  output logic       stackErr
);

  // Occupancy counter must represent 0..SHADOW_DEPTH inclusive.
  localparam int CNT_W = $clog2(SHADOW_DEPTH + 1);
  // Slot index width; the array is rounded up to a power of two so every
  // index value is in range.
  localparam int IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(SHADOW_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam bit               HAS_HOLD  = (INT_HOLD_CYCLES > 0);
  localparam logic [2:0]       HOLD_LAST = (INT_HOLD_CYCLES > 0) ?
                                           3'(INT_HOLD_CYCLES - 1) : 3'd0;

  // Operation classes.
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_SETC = 3'b011;
  localparam logic [2:0] OP_CLRC = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;

  // ALU mode encodings.
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_NOT  = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;
  localparam logic [1:0] MODE_NOP  = 2'b11;

  // Carry-select encodings.
  localparam logic [1:0] CS_RESET = 2'b00;
  localparam logic [1:0] CS_SET   = 2'b01;
  localparam logic [1:0] CS_ALU   = 2'b10;

  // Flag write masks, bit order {C,N,Z}.
  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_CNZ  = 3'b111;
  localparam logic [2:0] MASK_NZ   = 3'b011;
  localparam logic [2:0] MASK_C    = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SAVE = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // CCR bit cleared by a taken jump of the given type; JMP tests no flag.
  function automatic logic [2:0] jump_clear_mask(input logic [1:0] jt);
    logic [2:0] m;
    case (jt)
      2'b00:   m = 3'b001;  // JZ clears Z
      2'b01:   m = 3'b010;  // JN clears N
      2'b10:   m = 3'b100;  // JC clears C
      default: m = 3'b000;  // JMP
    endcase
    return m;
  endfunction

  state_t           state_r;
  state_t           state_next;
  logic [2:0]       hold_r;
  logic [2:0]       hold_next;
  logic [2:0]       ccr_r;
  logic [2:0]       ccr_next;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] top_idx_s;
  logic [2:0]       stack_r [SLOTS];
  logic             stack_err_r;

  logic             busy_s;
  logic             idle_s;
  logic             save_s;
  logic             full_s;
  logic             empty_s;
  logic             int_go_s;
  logic             rti_pop_s;
  logic             rti_err_s;
  logic [1:0]       mode_s;
  logic [1:0]       csel_s;
  logic [2:0]       mask_s;
  logic [2:0]       merged_s;

  assign idle_s    = (state_r == ST_IDLE);
  assign save_s    = (state_r == ST_SAVE);
  assign busy_s    = !idle_s;
  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == CNT_ZERO);
  assign top_idx_s = count_r - CNT_ONE;

  // A pending interrupt always beats a simultaneous RTI; with a full stack
  // the request simply stays pending and the RTI is still dropped.
  assign int_go_s  = idle_s && intReq && !full_s;
  assign rti_pop_s = idle_s && rtiReq && !intReq && !empty_s;
  assign rti_err_s = idle_s && rtiReq && !intReq && empty_s;

  // ALU control decode; stays live under stall, forced to NOP on flush/busy.
  always_comb begin
    mode_s = MODE_NOP;
    csel_s = CS_RESET;
    mask_s = MASK_NONE;
    if (flush || busy_s) begin
      mode_s = MODE_NOP;
      csel_s = CS_RESET;
      mask_s = MASK_NONE;
    end else begin
      case (aluOp)
        OP_ADD: begin
          mode_s = MODE_ADD;
          csel_s = CS_ALU;
          mask_s = MASK_CNZ;
        end
        OP_NOT: begin
          mode_s = MODE_NOT;
          csel_s = CS_ALU;
          mask_s = MASK_NZ;
        end
        OP_SETC: begin
          mode_s = MODE_NOP;
          csel_s = CS_SET;
          mask_s = MASK_C;
        end
        OP_CLRC: begin
          mode_s = MODE_NOP;
          csel_s = CS_RESET;
          mask_s = MASK_C;
        end
        OP_MOV: begin
          mode_s = MODE_PASS;
          csel_s = CS_RESET;
          mask_s = MASK_NONE;
        end
        default: begin
          mode_s = MODE_NOP;
          csel_s = CS_RESET;
          mask_s = MASK_NONE;
        end
      endcase
    end
  end

  // Interrupt sequencer next-state and hold-counter logic.
  always_comb begin
    state_next = state_r;
    hold_next  = hold_r;
    case (state_r)
      ST_IDLE: begin
        hold_next = 3'd0;
        if (int_go_s) begin
          state_next = ST_SAVE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SAVE: begin
        hold_next = 3'd0;
        if (HAS_HOLD) begin
          state_next = ST_HOLD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_r == HOLD_LAST) begin
          state_next = ST_IDLE;
          hold_next  = 3'd0;
        end else begin
          state_next = ST_HOLD;
          hold_next  = hold_r + 3'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        hold_next  = 3'd0;
      end
    endcase
  end

  // CCR next value: save/RTI action, then jump clear over the ALU merge.
  always_comb begin
    ccr_next = ccr_r;
    merged_s = (ccr_r & ~mask_s) | (aluFlags & mask_s);
    if (save_s) begin
      ccr_next = 3'b000;
    end else if (rti_pop_s) begin
      ccr_next = stack_r[top_idx_s[IDX_W-1:0]];
    end else if (rti_err_s) begin
      ccr_next = ccr_r;
    end else if (jumpTaken && !busy_s) begin
      // Clear is applied after the merge so it wins on its bit.
      ccr_next = merged_s & ~jump_clear_mask(jumpType);
    end else begin
      ccr_next = merged_s;
    end
  end

  // State, counter, CCR and shadow stack registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      hold_r      <= 3'd0;
      ccr_r       <= 3'b000;
      count_r     <= CNT_ZERO;
      stack_err_r <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        stack_r[i] <= 3'b000;
      end
    end else if (stall) begin
      // Everything architectural is frozen; no RTI is consumed this cycle.
      stack_err_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      hold_r      <= hold_next;
      ccr_r       <= ccr_next;
      stack_err_r <= rti_err_s;
      if (save_s) begin
        // The register value is pushed, not this cycle's ALU result.
        stack_r[count_r[IDX_W-1:0]] <= ccr_r;
        count_r                     <= count_r + CNT_ONE;
      end else if (rti_pop_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign AlUmode     = mode_s;
  assign carrySelect = csel_s;
  assign ccr         = ccr_r;
  assign busy        = busy_s;
  // Acknowledge only on a cycle where the save really takes effect.
  assign intAck      = save_s && !stall;
  assign stackErr    = stack_err_r;

endmodule

// File: tb/tb_alu_flag_controller.sv
// ---------------------------------------------------------------------------
// Self-checking bench for alu_flag_controller: directed scenarios with
// constant expectations, followed by randomized traffic checked against a
// behavioural model (CCR value, a queue as the shadow stack, a busy-cycle
// countdown).
// ---------------------------------------------------------------------------
module tb_alu_flag_controller;

  localparam int DEPTH = 2;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [2:0] aluOp;
  logic [2:0] aluFlags;
  logic       jumpTaken;
  logic [1:0] jumpType;
  logic       intReq;
  logic       rtiReq;
  logic [1:0] AlUmode;
  logic [1:0] carrySelect;
  logic [2:0] ccr;
  logic       intAck;
  logic       busy;
  logic       stackErr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_flag_controller #(
    .SHADOW_DEPTH    (DEPTH),
    .INT_HOLD_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .aluOp       (aluOp),
    .aluFlags    (aluFlags),
    .jumpTaken   (jumpTaken),
    .jumpType    (jumpType),
    .intReq      (intReq),
    .rtiReq      (rtiReq),
    .AlUmode     (AlUmode),
    .carrySelect (carrySelect),
    .ccr         (ccr),
    .intAck      (intAck),
    .busy        (busy),
    .stackErr    (stackErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    aluOp = 3'b000; aluFlags = 3'b000;
    jumpTaken = 1'b0; jumpType = 2'b00;
    intReq = 1'b0; rtiReq = 1'b0;
  endtask

  task automatic load_ccr(input logic [2:0] v);
    aluOp = 3'b001; aluFlags = v;
    tick();
    aluOp = 3'b000; aluFlags = 3'b000;
  endtask

  // Interrupt entry: request, save cycle, two hold cycles, back to idle.
  task automatic run_interrupt();
    intReq = 1'b1;
    tick();
    intReq = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL reset_ccr: got %b expected %b", ccr, 3'b000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (intAck !== 1'b0) begin errors++; $display("FAIL reset_intack: got %b expected %b", intAck, 1'b0); end
    checks++; if (stackErr !== 1'b0) begin errors++; $display("FAIL reset_stackerr: got %b expected %b", stackErr, 1'b0); end
  endtask

  task automatic test_alu_write();
    aluOp = 3'b001; aluFlags = 3'b101; #1;
    checks++; if (AlUmode !== 2'b00) begin errors++; $display("FAIL add_mode: got %b expected %b", AlUmode, 2'b00); end
    checks++; if (carrySelect !== 2'b10) begin errors++; $display("FAIL add_csel: got %b expected %b", carrySelect, 2'b10); end
    tick();
    aluOp = 3'b000; #1;
    checks++; if (ccr !== 3'b101) begin errors++; $display("FAIL add_ccr: got %b expected %b", ccr, 3'b101); end
    checks++; if (AlUmode !== 2'b11) begin errors++; $display("FAIL nop_mode: got %b expected %b", AlUmode, 2'b11); end
    aluOp = 3'b010; aluFlags = 3'b010; #1;
    checks++; if (AlUmode !== 2'b01) begin errors++; $display("FAIL not_mode: got %b expected %b", AlUmode, 2'b01); end
    checks++; if (carrySelect !== 2'b10) begin errors++; $display("FAIL not_csel: got %b expected %b", carrySelect, 2'b10); end
    tick();
    aluOp = 3'b000; #1;
    checks++; if (ccr !== 3'b110) begin errors++; $display("FAIL not_keeps_c: got %b expected %b", ccr, 3'b110); end
  endtask

  task automatic test_carry_ops();
    load_ccr(3'b010);
    aluOp = 3'b011; aluFlags = 3'b111; #1;
    checks++; if (AlUmode !== 2'b11) begin errors++; $display("FAIL setc_mode: got %b expected %b", AlUmode, 2'b11); end
    checks++; if (carrySelect !== 2'b01) begin errors++; $display("FAIL setc_csel: got %b expected %b", carrySelect, 2'b01); end
    tick();
    aluOp = 3'b100; aluFlags = 3'b001; #1;
    checks++; if (ccr !== 3'b110) begin errors++; $display("FAIL setc_ccr: got %b expected %b", ccr, 3'b110); end
    checks++; if (carrySelect !== 2'b00) begin errors++; $display("FAIL clrc_csel: got %b expected %b", carrySelect, 2'b00); end
    tick();
    aluOp = 3'b101; aluFlags = 3'b111; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL clrc_ccr: got %b expected %b", ccr, 3'b010); end
    checks++; if (AlUmode !== 2'b10) begin errors++; $display("FAIL mov_mode: got %b expected %b", AlUmode, 2'b10); end
    tick();
    aluOp = 3'b001; aluFlags = 3'b111; flush = 1'b1; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL mov_ccr: got %b expected %b", ccr, 3'b010); end
    checks++; if (AlUmode !== 2'b11) begin errors++; $display("FAIL flush_mode: got %b expected %b", AlUmode, 2'b11); end
    tick();
    flush = 1'b0; aluOp = 3'b110; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL flush_ccr: got %b expected %b", ccr, 3'b010); end
    checks++; if (AlUmode !== 2'b11) begin errors++; $display("FAIL op110_mode: got %b expected %b", AlUmode, 2'b11); end
    tick();
    aluOp = 3'b000; aluFlags = 3'b000; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL op110_ccr: got %b expected %b", ccr, 3'b010); end
  endtask

  task automatic test_jump_clear();
    load_ccr(3'b001);
    aluOp = 3'b001; aluFlags = 3'b011; jumpTaken = 1'b1; jumpType = 2'b00;
    tick();
    aluOp = 3'b000; aluFlags = 3'b000; jumpType = 2'b11; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL jz_wins: got %b expected %b", ccr, 3'b010); end
    tick();
    jumpType = 2'b01; #1;
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL jmp_nochange: got %b expected %b", ccr, 3'b010); end
    tick();
    jumpTaken = 1'b0; #1;
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL jn_clear: got %b expected %b", ccr, 3'b000); end
    load_ccr(3'b111);
    jumpTaken = 1'b1; jumpType = 2'b10;
    tick();
    jumpTaken = 1'b0; #1;
    checks++; if (ccr !== 3'b011) begin errors++; $display("FAIL jc_clear: got %b expected %b", ccr, 3'b011); end
  endtask

  task automatic test_interrupt();
    load_ccr(3'b110);
    intReq = 1'b1;
    tick();
    intReq = 1'b0; aluOp = 3'b001; aluFlags = 3'b111; #1;
    checks++; if (intAck !== 1'b1) begin errors++; $display("FAIL int_ack: got %b expected %b", intAck, 1'b1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL int_busy_save: got %b expected %b", busy, 1'b1); end
    checks++; if (AlUmode !== 2'b11) begin errors++; $display("FAIL int_busy_mode: got %b expected %b", AlUmode, 2'b11); end
    tick();
    jumpTaken = 1'b1; jumpType = 2'b00; #1;
    checks++; if (intAck !== 1'b0) begin errors++; $display("FAIL int_ack_once: got %b expected %b", intAck, 1'b0); end
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL int_ccr_clr: got %b expected %b", ccr, 3'b000); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL int_busy_h1: got %b expected %b", busy, 1'b1); end
    tick(); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL int_busy_h2: got %b expected %b", busy, 1'b1); end
    tick();
    aluOp = 3'b000; aluFlags = 3'b000; jumpTaken = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL int_busy_end: got %b expected %b", busy, 1'b0); end
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL int_add_ignored: got %b expected %b", ccr, 3'b000); end
    rtiReq = 1'b1;
    tick();
    rtiReq = 1'b0; #1;
    checks++; if (ccr !== 3'b110) begin errors++; $display("FAIL rti_restore: got %b expected %b", ccr, 3'b110); end
    checks++; if (stackErr !== 1'b0) begin errors++; $display("FAIL rti_no_err: got %b expected %b", stackErr, 1'b0); end
  endtask

  task automatic test_nested();
    load_ccr(3'b100);
    run_interrupt();
    load_ccr(3'b001);
    run_interrupt();
    #1;
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL nest_ccr: got %b expected %b", ccr, 3'b000); end
    intReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (intAck !== 1'b0) begin errors++; $display("FAIL full_no_ack: got %b expected %b", intAck, 1'b0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_no_busy: got %b expected %b", busy, 1'b0); end
    end
    intReq = 1'b0;
    rtiReq = 1'b1; tick(); rtiReq = 1'b0; #1;
    checks++; if (ccr !== 3'b001) begin errors++; $display("FAIL rti_first: got %b expected %b", ccr, 3'b001); end
    rtiReq = 1'b1; tick(); rtiReq = 1'b0; #1;
    checks++; if (ccr !== 3'b100) begin errors++; $display("FAIL rti_second: got %b expected %b", ccr, 3'b100); end
    rtiReq = 1'b1; tick(); rtiReq = 1'b0; #1;
    checks++; if (stackErr !== 1'b1) begin errors++; $display("FAIL rti_empty_err: got %b expected %b", stackErr, 1'b1); end
    checks++; if (ccr !== 3'b100) begin errors++; $display("FAIL rti_empty_ccr: got %b expected %b", ccr, 3'b100); end
    tick();
    checks++; if (stackErr !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected %b", stackErr, 1'b0); end
  endtask

  task automatic test_stall_reset();
    load_ccr(3'b011);
    intReq = 1'b1;
    tick();
    intReq = 1'b0; stall = 1'b1; #1;
    checks++; if (intAck !== 1'b0) begin errors++; $display("FAIL stall_no_ack: got %b expected %b", intAck, 1'b0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_save_busy: got %b expected %b", busy, 1'b1); end
    tick();
    checks++; if (ccr !== 3'b011) begin errors++; $display("FAIL stall_save_ccr: got %b expected %b", ccr, 3'b011); end
    stall = 1'b0; #1;
    checks++; if (intAck !== 1'b1) begin errors++; $display("FAIL unstall_ack: got %b expected %b", intAck, 1'b1); end
    tick();
    aluOp = 3'b001; aluFlags = 3'b111; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_hold_busy: got %b expected %b", busy, 1'b1); end
      checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL stall_hold_ccr: got %b expected %b", ccr, 3'b000); end
    end
    stall = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_resume: got %b expected %b", busy, 1'b1); end
    tick();
    aluOp = 3'b000; aluFlags = 3'b000; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_done: got %b expected %b", busy, 1'b0); end
    load_ccr(3'b101);
    intReq = 1'b1;
    tick();
    intReq = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL midrst_ccr: got %b expected %b", ccr, 3'b000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected %b", busy, 1'b0); end
    rtiReq = 1'b1; tick(); rtiReq = 1'b0; #1;
    checks++; if (stackErr !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected %b", stackErr, 1'b1); end
  endtask

  task automatic test_random();
    logic [2:0] m_ccr;
    logic [2:0] m_stack [$];
    bit         m_save;
    int         m_hold;
    bit         m_err;
    logic       e_busy;
    logic [1:0] e_mode;
    logic [1:0] e_cs;
    logic [2:0] e_mask;
    logic [2:0] alu_val;

    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ccr = 3'b000; m_stack.delete(); m_save = 1'b0; m_hold = 0; m_err = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst       = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      aluOp     = 3'($urandom_range(0, 7));
      aluFlags  = 3'($urandom_range(0, 7));
      jumpTaken = ($urandom_range(0, 2) == 0);
      jumpType  = 2'($urandom_range(0, 3));
      intReq    = ($urandom_range(0, 9) == 0);
      rtiReq    = ($urandom_range(0, 5) == 0);
      #1;

      e_busy = m_save || (m_hold > 0);
      {e_mode, e_cs, e_mask} = {2'b11, 2'b00, 3'b000};
      if (!flush && !e_busy) begin
        case (aluOp)
          3'b001:  {e_mode, e_cs, e_mask} = {2'b00, 2'b10, 3'b111};
          3'b010:  {e_mode, e_cs, e_mask} = {2'b01, 2'b10, 3'b011};
          3'b011:  {e_mode, e_cs, e_mask} = {2'b11, 2'b01, 3'b100};
          3'b100:  {e_mode, e_cs, e_mask} = {2'b11, 2'b00, 3'b100};
          3'b101:  {e_mode, e_cs, e_mask} = {2'b10, 2'b00, 3'b000};
          default: {e_mode, e_cs, e_mask} = {2'b11, 2'b00, 3'b000};
        endcase
      end

      checks++; if (AlUmode !== e_mode) begin errors++; $display("FAIL rnd_mode cyc %0d: got %b expected %b", cyc, AlUmode, e_mode); end
      checks++; if (carrySelect !== e_cs) begin errors++; $display("FAIL rnd_csel cyc %0d: got %b expected %b", cyc, carrySelect, e_cs); end
      checks++; if (ccr !== m_ccr) begin errors++; $display("FAIL rnd_ccr cyc %0d: got %b expected %b", cyc, ccr, m_ccr); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, e_busy); end
      checks++; if (intAck !== (m_save && !stall)) begin errors++; $display("FAIL rnd_intack cyc %0d: got %b expected %b", cyc, intAck, m_save && !stall); end
      checks++; if (stackErr !== m_err) begin errors++; $display("FAIL rnd_stackerr cyc %0d: got %b expected %b", cyc, stackErr, m_err); end

      // Flags the ALU/jump path would leave in an idle cycle.
      alu_val = (m_ccr & ~e_mask) | (aluFlags & e_mask);
      if (jumpTaken) begin
        case (jumpType)
          2'b00:   alu_val[0] = 1'b0;
          2'b01:   alu_val[1] = 1'b0;
          2'b10:   alu_val[2] = 1'b0;
          default: ;
        endcase
      end

      if (rst) begin
        m_ccr = 3'b000; m_stack.delete(); m_save = 1'b0; m_hold = 0; m_err = 1'b0;
      end else if (stall) begin
        m_err = 1'b0;
      end else if (m_save) begin
        m_stack.push_back(m_ccr);
        m_ccr = 3'b000; m_save = 1'b0; m_hold = HOLD; m_err = 1'b0;
      end else if (m_hold > 0) begin
        m_hold--; m_err = 1'b0;
      end else begin
        m_err = 1'b0;
        if (intReq) begin
          if (m_stack.size() < DEPTH) m_save = 1'b1;
          m_ccr = alu_val;
        end else if (rtiReq) begin
          if (m_stack.size() > 0) m_ccr = m_stack.pop_back();
          else m_err = 1'b1;
        end else begin
          m_ccr = alu_val;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_write();
    test_carry_ops();
    test_jump_clear();
    test_interrupt();
    test_nested();
    test_stall_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
